// File: rtl/tron_player_mover.sv
`default_nettype none
// ============================================================================
// Module   : tron_player_mover
// Purpose  : Light-cycle motion engine: turns button edges into heading
//            changes and steps a 7-bit wrapping X/Y location once per tick.
// Revision : 1.0 - initial release
// ============================================================================
module tron_player_mover #(
    parameter logic [7:0]  START_X   = 8'h03,
    parameter logic [7:0]  START_Y   = 8'h40,
    parameter logic [1:0]  START_DIR = 2'd1,
    parameter logic [23:0] TICK_DIV  = 24'd2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_init,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [7:0] gameover,
    output logic [7:0] LocX,
    output logic [7:0] LocY,
    output logic [1:0] heading,
    output logic       move_strobe,
    output logic       running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [23:0] c_tick_last = TICK_DIV - 24'd1;

    state_t      r_state;
    logic [23:0] r_cnt;
    logic        r_pend_valid;
    logic        r_pend_right;
    logic        r_init_d;
    logic        r_left_d;
    logic        r_right_d;
    logic [6:0]  r_loc_x;
    logic [6:0]  r_loc_y;
    logic [1:0]  r_heading;
    logic        r_strobe;
    logic        r_running;

    logic        w_init_rise;
    logic        w_left_rise;
    logic        w_right_rise;
    logic        w_turn_req;
    logic [1:0]  w_next_heading;
    logic [6:0]  w_next_x;
    logic [6:0]  w_next_y;
    logic        w_halt;
    logic        w_unused_gameover;

    assign w_init_rise  = game_init & ~r_init_d;
    assign w_left_rise  = btn_left  & ~r_left_d;
    assign w_right_rise = btn_right & ~r_right_d;
    // Simultaneous left and right edges cancel each other out.
    assign w_turn_req   = w_left_rise ^ w_right_rise;
    assign w_halt       = gameover[0];
    assign w_unused_gameover = ^gameover[7:1];

    always_comb begin
        w_next_heading = r_heading;
        if (r_pend_valid) begin
            w_next_heading = r_pend_right ? (r_heading + 2'd1) : (r_heading - 2'd1);
        end
    end

    // The step is taken in the already-turned heading; 7-bit adds wrap at 128.
    always_comb begin
        w_next_x = r_loc_x;
        w_next_y = r_loc_y;
        case (w_next_heading)
            2'd0:    w_next_y = r_loc_y - 7'd1;
            2'd1:    w_next_x = r_loc_x + 7'd1;
            2'd2:    w_next_y = r_loc_y + 7'd1;
            default: w_next_x = r_loc_x - 7'd1;
        endcase
    end

    always_ff @(posedge clk) begin
        r_init_d  <= game_init;
        r_left_d  <= btn_left;
        r_right_d <= btn_right;
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 24'd0;
            r_pend_valid <= 1'b0;
            r_pend_right <= 1'b0;
            r_loc_x      <= START_X[6:0];
            r_loc_y      <= START_Y[6:0];
            r_heading    <= START_DIR;
            r_strobe     <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt        <= 24'd0;
                    r_pend_valid <= 1'b0;
                    r_pend_right <= 1'b0;
                    r_loc_x      <= START_X[6:0];
                    r_loc_y      <= START_Y[6:0];
                    r_heading    <= START_DIR;
                    if (w_init_rise && !w_halt) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_halt) begin
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                    end else if (r_cnt == c_tick_last) begin
                        r_cnt        <= 24'd0;
                        r_heading    <= w_next_heading;
                        r_loc_x      <= w_next_x;
                        r_loc_y      <= w_next_y;
                        r_strobe     <= 1'b1;
                        // An edge coinciding with the move belongs to the next tick.
                        r_pend_valid <= w_turn_req;
                        r_pend_right <= w_right_rise;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                        if (!r_pend_valid && w_turn_req) begin
                            r_pend_valid <= 1'b1;
                            r_pend_right <= w_right_rise;
                        end
                    end
                end
                S_HALT: begin
                    if (!game_init) begin
                        r_state      <= S_IDLE;
                        r_pend_valid <= 1'b0;
                        r_pend_right <= 1'b0;
                        r_loc_x      <= START_X[6:0];
                        r_loc_y      <= START_Y[6:0];
                        r_heading    <= START_DIR;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign LocX        = {1'b0, r_loc_x};
    assign LocY        = {1'b0, r_loc_y};
    assign heading     = r_heading;
    assign move_strobe = r_strobe;
    assign running     = r_running;

endmodule
`default_nettype wire
